// File: rtl/lelo_temp_ctrl.sv
// rtl/lelo_temp_ctrl.sv - ring-oscillator temperature sensor controller (optional averaging: LELO_TEMP_AVG_EN)
module lelo_temp_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 32
) (
    input  logic             CK_1V8,
    input  logic             RST_1V8,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             OSC_TEMP_1V8,
    output logic             PWRUP_1V8,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] CNT,
    output logic             OVF
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        MEAS   = 2'd2,
        FIN    = 2'd3
    } state_t;

    // One timer serves both the settle phase and the window phase.
    localparam int SET_W         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMR_W         = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam int SETTLE_LAST_I = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               hist_q, hist_d;
    logic               pwrup_q, pwrup_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
`ifdef LELO_TEMP_AVG_EN
    logic [1:0]         pass_q, pass_d;
    logic [CNT_W+1:0]   acc_q, acc_d;
    logic               sat_any_q, sat_any_d;
`endif

    logic               rise;
    logic [TMR_W-1:0]   win_last;
    logic [CNT_W-1:0]   edge_inc;
    logic               sat_inc;

    assign PWRUP_1V8 = pwrup_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign CNT       = cnt_q;
    assign OVF       = ovf_q;

    // Next-state logic: synchronizer, edge counting, phase timers and result capture.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        win_d      = win_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        pwrup_d    = pwrup_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
`ifdef LELO_TEMP_AVG_EN
        pass_d     = pass_q;
        acc_d      = acc_q;
        sat_any_d  = sat_any_q;
`endif
        // History always tracks the synchronized level, so on MEAS entry it
        // already holds the current value and no stale edge is counted.
        sync1_d    = OSC_TEMP_1V8;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        rise       = sync2_q & ~hist_q;
        win_last   = TMR_W'(win_q - WIN_W'(1));

        // Count including this cycle's edge, stopping at full scale.
        edge_inc   = edge_cnt_q;
        sat_inc    = sat_q;
        if (state_q == MEAS && rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                edge_inc = edge_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    win_d      = (WINDOW == '0) ? WIN_W'(1) : WINDOW;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    ovf_d      = 1'b0;
                    tmr_d      = '0;
                    pwrup_d    = 1'b1;
                    state_d    = SETTLE;
`ifdef LELO_TEMP_AVG_EN
                    pass_d     = 2'd0;
                    acc_d      = '0;
                    sat_any_d  = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = MEAS;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            MEAS: begin
                edge_cnt_d = edge_inc;
                sat_d      = sat_inc;
                if (tmr_q == win_last) begin
                    tmr_d = '0;
`ifdef LELO_TEMP_AVG_EN
                    acc_d      = acc_q + (CNT_W+2)'(edge_inc);
                    sat_any_d  = sat_any_q | sat_inc;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    if (pass_q == 2'd3) begin
                        pwrup_d = 1'b0;
                        state_d = FIN;
                    end else begin
                        pass_d  = pass_q + 2'd1;
                        state_d = SETTLE;
                    end
`else
                    pwrup_d = 1'b0;
                    state_d = FIN;
`endif
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
`ifdef LELO_TEMP_AVG_EN
                cnt_d   = acc_q[CNT_W+1:2];
                ovf_d   = sat_any_q;
`else
                cnt_d   = edge_cnt_q;
                ovf_d   = sat_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset that aborts any measurement.
    always_ff @(posedge CK_1V8) begin
        if (RST_1V8) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            win_q      <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            pwrup_q    <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef LELO_TEMP_AVG_EN
            pass_q     <= 2'd0;
            acc_q      <= '0;
            sat_any_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            pwrup_q    <= pwrup_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
`ifdef LELO_TEMP_AVG_EN
            pass_q     <= pass_d;
            acc_q      <= acc_d;
            sat_any_q  <= sat_any_d;
`endif
        end
    end

endmodule

// File: tb/tb_lelo_temp_ctrl.sv
// tb/tb_lelo_temp_ctrl.sv - directed vector bench for lelo_temp_ctrl
module tb_lelo_temp_ctrl;

    localparam int SETTLE = 32;
`ifdef LELO_TEMP_AVG_EN
    localparam int PASSES = 4;
`else
    localparam int PASSES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] window;
    logic        osc = 1'b0;
    logic        osc_s = 1'b0;
    int          osc_half = 50;

    logic        pwr, busy, done, ovf;
    logic [15:0] cnt;
    logic        pwr_s, busy_s, done_s, ovf_s;
    logic [3:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    lelo_temp_ctrl #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut (
        .CK_1V8(clk), .RST_1V8(rst), .START(start), .WINDOW(window),
        .OSC_TEMP_1V8(osc), .PWRUP_1V8(pwr), .BUSY(busy), .DONE(done),
        .CNT(cnt), .OVF(ovf)
    );

    lelo_temp_ctrl #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut_s (
        .CK_1V8(clk), .RST_1V8(rst), .START(start), .WINDOW(window),
        .OSC_TEMP_1V8(osc_s), .PWRUP_1V8(pwr_s), .BUSY(busy_s), .DONE(done_s),
        .CNT(cnt_s), .OVF(ovf_s)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #3;
        forever #(osc_half) osc = ~osc;
    end

    initial begin
        #3;
        forever #20 osc_s = ~osc_s;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called at a negedge; returns DONE timing, PWRUP high count and DONE counts.
    task automatic run(input int w, input bit rep, output int lat, output int pwr_n,
                       output int dn, output int dn_s);
        int eff_w;
        int budget;
        eff_w  = (w == 0) ? 1 : w;
        budget = 2 + PASSES * (SETTLE + eff_w) + 5;
        lat = 0; pwr_n = 0; dn = 0; dn_s = 0;
        window = 16'(w);
        start  = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (pwr) pwr_n++;
            if (done) begin
                dn++;
                lat = n;
            end
            if (done_s) dn_s++;
            if (rep && (n == 5 || n == SETTLE + 200)) begin
                start  = 1'b1;
                window = 16'd7;
            end else begin
                start  = 1'b0;
                window = 16'(w);
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int window;
        int half;
        int cmin;
        int cmax;
        int smin;
        int smax;
        bit sovf;
        bit rep;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, pwr_n, dn, dn_s, eff_w, nd;

        vecs[0] = '{1000, 50, 99, 101, 15, 15, 1'b1, 1'b0};
        vecs[1] = '{1000, 50, 99, 101, 15, 15, 1'b1, 1'b1};
        vecs[2] = '{ 500, 25, 99, 101, 15, 15, 1'b1, 1'b0};
        vecs[3] = '{   0, 50,  0,   1,  0,  1, 1'b0, 1'b0};
        vecs[4] = '{   1, 50,  0,   1,  0,  1, 1'b0, 1'b0};
        vecs[5] = '{ 300, 15, 99, 101, 15, 15, 1'b1, 1'b0};
        vecs[6] = '{  40, 100, 1,   3,  9, 11, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; window = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_pwrup", int'(pwr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            osc_half = vecs[i].half;
            repeat (20) @(negedge clk);
            eff_w = (vecs[i].window == 0) ? 1 : vecs[i].window;
            run(vecs[i].window, vecs[i].rep, lat, pwr_n, dn, dn_s);
            chk($sformatf("v%0d_latency", i), lat, 2 + PASSES * (SETTLE + eff_w));
            chk($sformatf("v%0d_done_count", i), dn, 1);
            chk($sformatf("v%0d_pwrup_cycles", i), pwr_n, PASSES * (SETTLE + eff_w));
            chk_rng($sformatf("v%0d_cnt", i), int'(cnt), vecs[i].cmin, vecs[i].cmax);
            chk($sformatf("v%0d_ovf", i), int'(ovf), 0);
            chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
            chk($sformatf("v%0d_small_done_count", i), dn_s, 1);
            chk_rng($sformatf("v%0d_small_cnt", i), int'(cnt_s), vecs[i].smin, vecs[i].smax);
            chk($sformatf("v%0d_small_ovf", i), int'(ovf_s), int'(vecs[i].sovf));
        end

        // Reset in the middle of MEAS, coinciding with a START request.
        osc_half = 50;
        repeat (20) @(negedge clk);
        window = 16'd1000;
        start  = 1'b1;
        nd = 0;
        for (int n = 1; n <= SETTLE + 500; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd++;
        end
        chk("abort_pwrup_before", int'(pwr), 1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_pwrup", int'(pwr), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cnt", int'(cnt), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_small_cnt", int'(cnt_s), 0);
        rst   = 1'b0;
        start = 1'b0;
        for (int n = 0; n < 1100; n++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nd++;
        end
        chk("abort_no_done_or_busy", nd, 0);

        run(1000, 1'b0, lat, pwr_n, dn, dn_s);
        chk("after_abort_latency", lat, 2 + PASSES * (SETTLE + 1000));
        chk("after_abort_done_count", dn, 1);
        chk("after_abort_pwrup_cycles", pwr_n, PASSES * (SETTLE + 1000));
        chk_rng("after_abort_cnt", int'(cnt), 99, 101);
        chk("after_abort_ovf", int'(ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
